// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if: producer stream, consumer stream and external RAM port
// of the RAM-backed FIFO controller, bundled so that one connection covers
// the whole controller.
interface ram_fifo_ctrl_if #(
  parameter int C_WIDTH = 32,
  parameter int C_DEPTH = 512
);
  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = $clog2(C_DEPTH + 1);

  // producer side
  logic [C_WIDTH-1:0] wr_data;
  logic               wr_valid;
  logic               wr_ready;
  // consumer side
  logic [C_WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               rd_ready;
  // occupancy
  logic [CW-1:0]      count;
  // external RAM
  logic               ram_we;
  logic [AW-1:0]      ram_waddr;
  logic [C_WIDTH-1:0] ram_wdata;
  logic [AW-1:0]      ram_raddr;
  logic [C_WIDTH-1:0] ram_rdata;

  // controller view
  modport slave (
    input  wr_data, wr_valid, rd_ready, ram_rdata,
    output wr_ready, rd_data, rd_valid, count,
           ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  // environment view: producer, consumer and RAM model
  modport master (
    output wr_data, wr_valid, rd_ready, ram_rdata,
    input  wr_ready, rd_data, rd_valid, count,
           ram_we, ram_waddr, ram_wdata, ram_raddr
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: first-word-fall-through FIFO controller around an external
// 1W/1R RAM with registered read data. A 2-entry output buffer hides the
// one-cycle RAM read latency so the FIFO sustains one word per cycle.
module ram_fifo_ctrl #(
  parameter int C_WIDTH = 32,
  parameter int C_DEPTH = 512
) (
  input logic            clk,
  input logic            rst_n,
  ram_fifo_ctrl_if.slave bus
);
  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = $clog2(C_DEPTH + 1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(C_DEPTH);

  // pointers carry one extra MSB so full and empty RAM differ
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic               inflight;
  logic [1:0]         buf_count;
  logic [C_WIDTH-1:0] buf_head;
  logic [C_WIDTH-1:0] buf_tail;
  logic [CW-1:0]      count;

  logic               accept;
  logic               pop;
  logic               issue;
  logic               ram_nonempty;
  logic [2:0]         buf_demand;

  // COUNT covers RAM, in-flight and buffered words, so it alone gates writes;
  // a pop in the same cycle does not open a slot until the next cycle
  assign bus.wr_ready  = rst_n & (count < CNT_FULL);
  assign accept        = bus.wr_valid & bus.wr_ready;
  assign bus.ram_we    = accept;
  assign bus.ram_waddr = wptr[AW-1:0];
  assign bus.ram_wdata = bus.wr_data;

  assign bus.rd_valid  = (buf_count != 2'd0);
  assign bus.rd_data   = buf_head;
  assign pop           = bus.rd_valid & bus.rd_ready;
  assign bus.count     = count;

  // prefetch only while the buffer plus the word in flight leaves room,
  // counting the slot freed by this cycle's pop
  assign ram_nonempty  = (wptr != rptr);
  assign buf_demand    = {1'b0, buf_count} + {2'b0, inflight} - {2'b0, pop};
  assign issue         = ram_nonempty & (buf_demand < 3'd2);
  assign bus.ram_raddr = rptr[AW-1:0];

  // write pointer advances on every accepted word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (accept) begin
      wptr <= wptr + PTR_ONE;
    end
  end

  // read pointer and in-flight flag follow each RAM read issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rptr <= rptr + PTR_ONE;
      end
    end
  end

  // 2-entry output buffer: capture RAM data the cycle after an issue, shift on pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_count <= 2'd0;
      buf_head  <= '0;
      buf_tail  <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (buf_count == 2'd0) begin
            buf_head <= bus.ram_rdata;
          end else begin
            buf_tail <= bus.ram_rdata;
          end
          buf_count <= buf_count + 2'd1;
        end
        2'b01: begin
          buf_head  <= buf_tail;
          buf_count <= buf_count - 2'd1;
        end
        2'b11: begin
          if (buf_count == 2'd1) begin
            buf_head <= bus.ram_rdata;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= bus.ram_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // total held words: up on accept, down on pop, unchanged when both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: scenario tasks driving ram_fifo_ctrl with a registered
// RAM model; expectations come from a word queue and simple counters.
module tb_ram_fifo_ctrl;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int CW = $clog2(D + 1);
  localparam int AW = $clog2(D);
  localparam int N_RAND = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   total_wr = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl_if #(.C_WIDTH(W), .C_DEPTH(D)) bus ();

  ram_fifo_ctrl #(.C_WIDTH(W), .C_DEPTH(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // external RAM: one write port, registered read data
  logic [W-1:0] mem [D];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_data = '0;
    bus.rd_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b want 0", bus.wr_ready); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.count !== CW'(0)) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", bus.ram_we); end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL release_wr_ready: got %b want 1", bus.wr_ready); end
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL release_rd_valid: got %b want 0", bus.rd_valid); end
    next_cycle();
  endtask

  task automatic test_single_write();
    bus.wr_data = 32'hA5A5_0001;
    bus.wr_valid = 1'b1;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.ram_we !== 1'b1) begin n_err++; $display("FAIL single_ram_we: got %b want 1", bus.ram_we); end
    n_cmp++; if (bus.ram_waddr !== AW'(0)) begin n_err++; $display("FAIL single_waddr: got %0d want 0", bus.ram_waddr); end
    n_cmp++; if (bus.ram_wdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_wdata: got %h want a5a50001", bus.ram_wdata); end
    next_cycle();
    total_wr++;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t1: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.count !== CW'(1)) begin n_err++; $display("FAIL single_count_t1: got %0d want 1", bus.count); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t2: got %b want 0", bus.rd_valid); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_t3: got %b want 1", bus.rd_valid); end
    n_cmp++; if (bus.rd_data !== 32'hA5A5_0001) begin n_err++; $display("FAIL single_rd_data: got %h want a5a50001", bus.rd_data); end
    n_cmp++; if (bus.count !== CW'(1)) begin n_err++; $display("FAIL single_count_t3: got %0d want 1", bus.count); end
    bus.rd_ready = 1'b1;
    next_cycle();
    bus.rd_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL single_drained_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.count !== CW'(0)) begin n_err++; $display("FAIL single_drained_count: got %0d want 0", bus.count); end
    next_cycle();
  endtask

  task automatic test_fill_full();
    int exp_word;
    int budget;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      bus.wr_data = W'(i);
      bus.wr_valid = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL fill_wr_ready[%0d]: got %b want 1", i, bus.wr_ready); end
      n_cmp++; if (bus.ram_waddr !== AW'(total_wr % D)) begin n_err++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, bus.ram_waddr, total_wr % D); end
      next_cycle();
      total_wr++;
    end
    bus.wr_data = 32'd99;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL full_wr_ready[%0d]: got %b want 0", i, bus.wr_ready); end
      n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL full_ram_we[%0d]: got %b want 0", i, bus.ram_we); end
      n_cmp++; if (bus.count !== CW'(D)) begin n_err++; $display("FAIL full_count[%0d]: got %0d want %0d", i, bus.count, D); end
      next_cycle();
    end
    bus.rd_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rd_data !== 32'd0 || bus.rd_valid !== 1'b1) begin n_err++; $display("FAIL full_pop_head: got %h/%b want 0/1", bus.rd_data, bus.rd_valid); end
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL full_pop_wr_ready: got %b want 0", bus.wr_ready); end
    next_cycle();
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL after_pop_wr_ready: got %b want 1", bus.wr_ready); end
    n_cmp++; if (bus.count !== CW'(D - 1)) begin n_err++; $display("FAIL after_pop_count: got %0d want %0d", bus.count, D - 1); end
    next_cycle();
    exp_word = 1;
    budget = 0;
    bus.rd_ready = 1'b1;
    while (exp_word < D && budget < 50) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        n_cmp++; if (bus.rd_data !== W'(exp_word)) begin n_err++; $display("FAIL fill_drain_data: got %0d want %0d", bus.rd_data, exp_word); end
        exp_word++;
      end
      next_cycle();
      budget++;
    end
    bus.rd_ready = 1'b0;
    n_cmp++; if (exp_word != D) begin n_err++; $display("FAIL fill_drain_timeout: got %0d words want %0d", exp_word - 1, D - 1); end
    @(negedge clk);
    n_cmp++; if (bus.count !== CW'(0) || bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL fill_drain_empty: got count %0d valid %b want 0/0", bus.count, bus.rd_valid); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int n_in;
    int n_out;
    int first;
    int last;
    int k;
    int base;
    logic acc;
    n_in = 0; n_out = 0; first = -1; last = -1; k = 0;
    base = total_wr;
    bus.rd_ready = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data = '0;
    while (n_out < 20 && k < 100) begin
      @(negedge clk);
      n_cmp++; if (bus.count !== CW'(n_in - n_out)) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want %0d", k, bus.count, n_in - n_out); end
      acc = 1'b0;
      if (n_in < 20) begin
        n_cmp++; if (bus.wr_ready !== 1'b1) begin n_err++; $display("FAIL stream_wr_ready[%0d]: got %b want 1", k, bus.wr_ready); end
        if (bus.wr_ready === 1'b1) begin
          acc = 1'b1;
          n_cmp++; if (bus.ram_waddr !== AW'((base + n_in) % D)) begin n_err++; $display("FAIL stream_waddr[%0d]: got %0d want %0d", n_in, bus.ram_waddr, (base + n_in) % D); end
        end
      end
      if (bus.rd_valid === 1'b1) begin
        n_cmp++; if (bus.rd_data !== W'(n_out)) begin n_err++; $display("FAIL stream_data[%0d]: got %0d want %0d", n_out, bus.rd_data, n_out); end
        if (first < 0) first = k;
        last = k;
        n_out++;
      end
      next_cycle();
      if (acc) begin
        n_in++;
        total_wr++;
      end
      bus.wr_data = W'(n_in);
      bus.wr_valid = (n_in < 20);
      k++;
    end
    bus.rd_ready = 1'b0;
    bus.wr_valid = 1'b0;
    n_cmp++; if (n_out != 20) begin n_err++; $display("FAIL stream_timeout: got %0d words want 20", n_out); end
    n_cmp++; if (first != 3) begin n_err++; $display("FAIL stream_first_out: got cycle %0d want 3", first); end
    n_cmp++; if (last != 22) begin n_err++; $display("FAIL stream_last_out: got cycle %0d want 22", last); end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp_word;
    int n_in;
    int n_out;
    int cyc;
    n_in = 0; n_out = 0; cyc = 0;
    while (n_out < N_RAND && cyc < 20000) begin
      bus.wr_valid = (n_in < N_RAND) && ($urandom_range(0, 1) == 1);
      bus.wr_data = $urandom;
      bus.rd_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      n_cmp++; if (bus.count !== CW'(q.size())) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", cyc, bus.count, q.size()); end
      n_cmp++; if (bus.wr_ready !== (q.size() < D)) begin n_err++; $display("FAIL rand_wr_ready[%0d]: got %b want %b", cyc, bus.wr_ready, q.size() < D); end
      if (q.size() == D) begin
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL rand_write_when_full[%0d]: got %b want 0", cyc, bus.ram_we); end
      end
      if (bus.rd_valid === 1'b1 && q.size() == 0) begin
        n_cmp++; n_err++; $display("FAIL rand_valid_when_empty[%0d]: got 1 want 0", cyc);
      end else if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
        exp_word = q.pop_front();
        n_cmp++; if (bus.rd_data !== exp_word) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", n_out, bus.rd_data, exp_word); end
        n_out++;
      end
      if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
        q.push_back(bus.wr_data);
        n_in++;
        total_wr++;
      end
      next_cycle();
      cyc++;
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    n_cmp++; if (n_out != N_RAND) begin n_err++; $display("FAIL rand_timeout: got %0d words want %0d", n_out, N_RAND); end
  endtask

  task automatic test_empty_read();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_rd_valid[%0d]: got %b want 0", i, bus.rd_valid); end
      n_cmp++; if (bus.count !== CW'(0)) begin n_err++; $display("FAIL empty_count[%0d]: got %0d want 0", i, bus.count); end
      n_cmp++; if (bus.ram_raddr !== AW'(total_wr % D)) begin n_err++; $display("FAIL empty_raddr[%0d]: got %0d want %0d", i, bus.ram_raddr, total_wr % D); end
      next_cycle();
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int budget;
    logic seen;
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.wr_data = 32'hC000_0000 + W'(i);
      bus.wr_valid = 1'b1;
      next_cycle();
    end
    bus.wr_data = 32'h0000_0BAD;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.rd_valid !== 1'b0) begin n_err++; $display("FAIL midrst_rd_valid: got %b want 0", bus.rd_valid); end
    n_cmp++; if (bus.count !== CW'(0)) begin n_err++; $display("FAIL midrst_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.wr_ready !== 1'b0) begin n_err++; $display("FAIL midrst_wr_ready: got %b want 0", bus.wr_ready); end
    next_cycle();
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b0 || bus.count !== CW'(0)) begin n_err++; $display("FAIL midrst_release: got valid %b count %0d want 0/0", bus.rd_valid, bus.count); end
    next_cycle();
    bus.wr_data = 32'h0000_1234;
    bus.wr_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.ram_we !== 1'b1 || bus.ram_waddr !== AW'(0)) begin n_err++; $display("FAIL midrst_first_write: got we %b addr %0d want 1/0", bus.ram_we, bus.ram_waddr); end
    next_cycle();
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b1;
    budget = 0;
    seen = 1'b0;
    while (!seen && budget < 20) begin
      @(negedge clk);
      if (bus.rd_valid === 1'b1) begin
        seen = 1'b1;
        n_cmp++; if (bus.rd_data !== 32'h0000_1234) begin n_err++; $display("FAIL midrst_first_read: got %h want 00001234", bus.rd_data); end
      end
      next_cycle();
      budget++;
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL midrst_read_timeout: got none want 00001234"); end
    @(negedge clk);
    n_cmp++; if (bus.rd_valid !== 1'b0 || bus.count !== CW'(0)) begin n_err++; $display("FAIL midrst_final_empty: got valid %b count %0d want 0/0", bus.rd_valid, bus.count); end
    bus.rd_ready = 1'b0;
    next_cycle();
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.rd_ready = 1'b0;
    test_reset();
    test_single_write();
    test_fill_full();
    test_back_to_back();
    test_random();
    test_empty_read();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
